// File: rtl/segment_mixer_pkg.sv
// segment_mixer_pkg
//   Shared definitions for the segment mixer slice: default parameter
//   values, the background colour and the slot-index width helper.
//   No ports; imported by segment_mixer and seg_hit.
package segment_mixer_pkg;

    localparam int DEF_N_SEG    = 4;
    localparam int DEF_POS_W    = 10;
    localparam int DEF_COL_W    = 8;
    localparam int DEF_LINE_LEN = 1024;

    // Colour emitted when no enabled segment covers the pixel.
    localparam int BG_COL = 0;

    // Slot index width: at least one bit, even for a single slot.
    function automatic int idx_width(input int n_seg);
        return (n_seg > 1) ? $clog2(n_seg) : 1;
    endfunction

endpackage

// File: rtl/seg_hit.sv
// seg_hit
//   Purely combinational coverage test for one segment slot.
//   Ports:
//     seg_pos  in  POS_W  segment start
//     seg_size in  POS_W  segment length (0 never hits)
//     seg_en   in  1      slot enable
//     p        in  POS_W  position under test
//     hit      out 1      slot is enabled and covers p
module seg_hit
    import segment_mixer_pkg::*;
#(
    parameter int POS_W = DEF_POS_W
) (
    input  logic [POS_W-1:0] seg_pos,
    input  logic [POS_W-1:0] seg_size,
    input  logic             seg_en,
    input  logic [POS_W-1:0] p,
    output logic             hit
);

    // One extra bit so a segment running past the top of the position
    // range saturates instead of wrapping back to low positions.
    logic [POS_W:0] seg_end;

    assign seg_end = {1'b0, seg_pos} + {1'b0, seg_size};
    assign hit     = seg_en && (seg_pos <= p) && ({1'b0, p} < seg_end);

endmodule

// File: rtl/segment_mixer.sv
// segment_mixer
//   Holds N_SEG programmable 1-D segments, scans its own line position
//   counter and emits, one cycle later, the colour of the lowest-index
//   enabled segment covering each scanned position.
//   Ports:
//     clk        in  1      clock, all state on the rising edge
//     rst        in  1      synchronous reset, active-low
//     run        in  1      advance the scan and emit one pixel
//     cfg_we     in  1      write slot cfg_idx (ignored if >= N_SEG)
//     cfg_idx    in  IDX_W  slot index
//     cfg_pos    in  POS_W  segment start
//     cfg_size   in  POS_W  segment length
//     cfg_col    in  COL_W  segment colour
//     cfg_en     in  1      slot enable
//     out_vld    out 1      out_* carry a pixel this cycle
//     out_pos    out POS_W  position of the emitted pixel
//     out_col    out COL_W  resolved colour, background when no hit
//     out_hit    out 1      some enabled segment covers out_pos
//     out_idx    out IDX_W  winning slot, 0 when no hit
//     line_start out 1      pixel at position 0
//
//   Output handshake: out_vld is a valid-only strobe with no ready. Every
//   cycle out_vld is high the sink must take the pixel; while out_vld is
//   low the out_pos/col/hit/idx values simply hold and carry no pixel.
module segment_mixer
    import segment_mixer_pkg::*;
#(
    parameter  int N_SEG    = DEF_N_SEG,
    parameter  int POS_W    = DEF_POS_W,
    parameter  int COL_W    = DEF_COL_W,
    parameter  int LINE_LEN = DEF_LINE_LEN,
    localparam int IDX_W    = idx_width(N_SEG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [POS_W-1:0] cfg_pos,
    input  logic [POS_W-1:0] cfg_size,
    input  logic [COL_W-1:0] cfg_col,
    input  logic             cfg_en,
    output logic             out_vld,
    output logic [POS_W-1:0] out_pos,
    output logic [COL_W-1:0] out_col,
    output logic             out_hit,
    output logic [IDX_W-1:0] out_idx,
    output logic             line_start
);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(LINE_LEN - 1);

    logic [POS_W-1:0] cnt;

    logic [POS_W-1:0] seg_pos  [N_SEG];
    logic [POS_W-1:0] seg_size [N_SEG];
    logic [COL_W-1:0] seg_col  [N_SEG];
    logic             seg_en   [N_SEG];

    logic [N_SEG-1:0] hit_vec;

    logic             win_hit;
    logic [IDX_W-1:0] win_idx;
    logic [COL_W-1:0] win_col;

    for (genvar k = 0; k < N_SEG; k++) begin : g_hit
        seg_hit #(.POS_W(POS_W)) u_hit (
            .seg_pos  (seg_pos[k]),
            .seg_size (seg_size[k]),
            .seg_en   (seg_en[k]),
            .p        (cnt),
            .hit      (hit_vec[k])
        );
    end

    // Priority mux: walk from the highest index down so the lowest-index
    // hitting slot is the last assignment and therefore wins.
    always_comb begin
        win_hit = 1'b0;
        win_idx = '0;
        win_col = COL_W'(BG_COL);
        for (int k = N_SEG - 1; k >= 0; k--) begin
            if (hit_vec[k]) begin
                win_hit = 1'b1;
                win_idx = IDX_W'(k);
                win_col = seg_col[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            out_vld    <= 1'b0;
            out_pos    <= '0;
            out_col    <= '0;
            out_hit    <= 1'b0;
            out_idx    <= '0;
            line_start <= 1'b0;
            for (int k = 0; k < N_SEG; k++) begin
                seg_pos[k]  <= '0;
                seg_size[k] <= '0;
                seg_col[k]  <= '0;
                seg_en[k]   <= 1'b0;
            end
        end else begin
            // Slot writes land at this edge; the pixel resolved this cycle
            // used the old contents. Indices past N_SEG match no slot.
            for (int k = 0; k < N_SEG; k++) begin
                if (cfg_we && (cfg_idx == IDX_W'(k))) begin
                    seg_pos[k]  <= cfg_pos;
                    seg_size[k] <= cfg_size;
                    seg_col[k]  <= cfg_col;
                    seg_en[k]   <= cfg_en;
                end
            end

            out_vld    <= run;
            line_start <= run && (cnt == '0);

            if (run) begin
                out_pos <= cnt;
                out_col <= win_col;
                out_hit <= win_hit;
                out_idx <= win_idx;
                cnt     <= (cnt == LAST_POS) ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_segment_mixer.sv
// tb_segment_mixer
//   Self-checking bench for segment_mixer. The driver keeps a plain
//   array model of the slots and the scan position, pushes the expected
//   pixel for every run cycle, and a monitor pops and compares whenever
//   the design presents out_vld. Five slots are used so that index 7 is
//   representable on the 3-bit cfg_idx and exercises the ignored write.
module tb_segment_mixer;

    localparam int N_SEG    = 5;
    localparam int POS_W    = 10;
    localparam int COL_W    = 8;
    localparam int LINE_LEN = 1024;
    localparam int IDX_W    = 3;
    localparam int EW       = 2 + IDX_W + POS_W + COL_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             run;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [POS_W-1:0] cfg_pos;
    logic [POS_W-1:0] cfg_size;
    logic [COL_W-1:0] cfg_col;
    logic             cfg_en;
    logic             out_vld;
    logic [POS_W-1:0] out_pos;
    logic [COL_W-1:0] out_col;
    logic             out_hit;
    logic [IDX_W-1:0] out_idx;
    logic             line_start;

    segment_mixer #(
        .N_SEG    (N_SEG),
        .POS_W    (POS_W),
        .COL_W    (COL_W),
        .LINE_LEN (LINE_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_pos    (cfg_pos),
        .cfg_size   (cfg_size),
        .cfg_col    (cfg_col),
        .cfg_en     (cfg_en),
        .out_vld    (out_vld),
        .out_pos    (out_pos),
        .out_col    (out_col),
        .out_hit    (out_hit),
        .out_idx    (out_idx),
        .line_start (line_start)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    // Reference model: slot table and scan position.
    int m_pos  [N_SEG];
    int m_size [N_SEG];
    int m_col  [N_SEG];
    bit m_en   [N_SEG];
    int m_cnt;

    function automatic logic [EW-1:0] pack_exp(bit ls, bit hit, int idx, int pos, int col);
        logic [EW-1:0] v;
        v = {ls, hit, IDX_W'(idx), POS_W'(pos), COL_W'(col)};
        return v;
    endfunction

    // First enabled slot whose [pos, pos+size) interval contains p.
    function automatic logic [EW-1:0] ref_pixel(int p);
        int w;
        w = -1;
        for (int k = 0; k < N_SEG; k++) begin
            if (w < 0 && m_en[k] && p >= m_pos[k] && p < m_pos[k] + m_size[k]) w = k;
        end
        if (w < 0) return pack_exp(p == 0, 1'b0, 0, p, 0);
        return pack_exp(p == 0, 1'b1, w, p, m_col[w]);
    endfunction

    task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got ls=%0b hit=%0b idx=%0d pos=%0d col=%0d, expected ls=%0b hit=%0b idx=%0d pos=%0d col=%0d",
                     name, $time,
                     got[EW-1], got[EW-2], got[EW-3 -: IDX_W], got[POS_W+COL_W-1 -: POS_W], got[COL_W-1:0],
                     exp[EW-1], exp[EW-2], exp[EW-3 -: IDX_W], exp[POS_W+COL_W-1 -: POS_W], exp[COL_W-1:0]);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit r, input bit rn, input bit we, input int idx,
                         input int pos, input int size, input int col, input bit en);
        rst      = r;
        run      = rn;
        cfg_we   = we;
        cfg_idx  = IDX_W'(idx);
        cfg_pos  = POS_W'(pos);
        cfg_size = POS_W'(size);
        cfg_col  = COL_W'(col);
        cfg_en   = en;
        if (!r) begin
            for (int k = 0; k < N_SEG; k++) begin
                m_pos[k] = 0; m_size[k] = 0; m_col[k] = 0; m_en[k] = 1'b0;
            end
            m_cnt = 0;
        end else begin
            if (rn) begin
                exp_q.push_back(ref_pixel(m_cnt));
                m_cnt = (m_cnt + 1) % LINE_LEN;
            end
            if (we && idx < N_SEG) begin
                m_pos[idx] = pos; m_size[idx] = size; m_col[idx] = col; m_en[idx] = en;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step_run(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 2 * LINE_LEN && m_cnt != target; i++) drive(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic write_slot(input int idx, input int pos, input int size, input int col,
                              input bit en, input bit rn);
        drive(1'b1, rn, 1'b1, idx, pos, size, col, en);
    endtask

    // ---------------- monitor ----------------
    logic          rst_q = 1'b0;
    logic [EW-2:0] held  = '0;
    logic [EW-1:0] mon_e;

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        if (!rst_q) begin
            check("reset_vld", EW'(out_vld), '0);
            check("reset_out", {line_start, out_hit, out_idx, out_pos, out_col}, '0);
            held = '0;
        end else if (out_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel at %0t: got pos=%0d col=%0d, expected no pixel",
                         $time, out_pos, out_col);
            end else begin
                mon_e = exp_q.pop_front();
                check("pixel", {line_start, out_hit, out_idx, out_pos, out_col}, mon_e);
                held = mon_e[EW-2:0];
            end
        end else begin
            check("idle_hold", {line_start, out_hit, out_idx, out_pos, out_col}, {1'b0, held});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; run = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_pos = '0; cfg_size = '0; cfg_col = '0; cfg_en = 1'b0;
        for (int k = 0; k < N_SEG; k++) begin
            m_pos[k] = 0; m_size[k] = 0; m_col[k] = 0; m_en[k] = 1'b0;
        end
        m_cnt = 0;

        // Reset for three cycles; the write in the middle must be dropped.
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 0, 10, 20, 7, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);

        // Empty scan across a full line and its wrap.
        step_run(1030);

        // Overlap priority.
        write_slot(0, 100, 100, 1, 1'b1, 1'b0);
        write_slot(1, 50, 100, 2, 1'b1, 1'b0);
        step_run(1024);

        // Boundaries: tail past the line end, zero size, out-of-range index.
        write_slot(1, 0, 0, 0, 1'b0, 1'b0);
        write_slot(0, 1020, 10, 5, 1'b1, 1'b0);
        write_slot(2, 300, 0, 4, 1'b1, 1'b0);
        write_slot(7, 0, 1023, 6, 1'b1, 1'b0);
        write_slot(5, 0, 1023, 6, 1'b1, 1'b0);
        write_slot(6, 0, 1023, 6, 1'b1, 1'b1);
        step_run(1030);

        // Run gating from count 10.
        run_to(10);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);

        // Live recolour while the scan is inside the segment.
        write_slot(0, 100, 100, 3, 1'b1, 1'b0);
        run_to(150);
        write_slot(0, 100, 100, 9, 1'b1, 1'b1);
        step_run(5);

        // Mid-line reset, then a full line that must be all background.
        run_to(500);
        drive(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        step_run(1100);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r_i, rn_i, we_i;
            int sz;
            r_i  = ($urandom_range(0, 499) != 0);
            rn_i = ($urandom_range(0, 3) != 0);
            we_i = ($urandom_range(0, 9) == 0);
            sz   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : $urandom_range(0, 1023);
            drive(r_i, rn_i, we_i, $urandom_range(0, 7), $urandom_range(0, 1023), sz,
                  $urandom_range(0, 255), 1'($urandom_range(0, 1)));
        end

        // Drain and confirm every expected pixel was seen.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pixels still expected, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
